// File: rtl/shift_op_sequencer.sv
// shift_op_sequencer: multi-cycle SRL/SRA/SLL execution stage wrapped around a logical-right-shift core.
// Optional ROR on op 11 when SHIFT_ROTATE_EN is defined; otherwise op 11 reports o_illegal.
module shift_rshift_core (
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_data
);
  assign o_data = i_data >> i_shamt;
endmodule

module shift_op_sequencer #(
  parameter int unsigned MASK_SHAMT  = 1,
  parameter int unsigned CALC_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_operand,
  input  logic [31:0] i_shamt,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_result,
  output logic        o_illegal,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  localparam logic [1:0] OP_SRL = 2'd0;
  localparam logic [1:0] OP_SRA = 2'd1;
  localparam logic [1:0] OP_SLL = 2'd2;
  localparam logic [2:0] LAST   = 3'(CALC_CYCLES);

  if (CALC_CYCLES < 1 || CALC_CYCLES > 4) begin : g_bad_calc_cycles
    $error("shift_op_sequencer: CALC_CYCLES must be in 1..4");
  end

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    for (int i = 0; i < 32; i++) bitrev[i] = v[31-i];
  endfunction

  state_t      state_q;
  logic [1:0]  op_q;
  logic [31:0] operand_q;
  logic [31:0] shamt_q;
  logic [2:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        illegal_q;
  logic        busy_q;
  logic [31:0] result_q;

  logic [31:0] shamt_d;
  logic [31:0] core_in;
  logic [31:0] core_out;
  logic [31:0] fill_out;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic [31:0] sll_res;
  logic [31:0] ror_res;
  logic        ror_ill;
  logic [31:0] result_d;
  logic        illegal_d;
  logic        sat;
  logic        sign;

  assign shamt_d = (MASK_SHAMT != 0) ? {27'b0, i_shamt[4:0]} : i_shamt;
  assign sign    = operand_q[31];
  assign sat     = |shamt_q[31:5];
  assign core_in = (op_q == OP_SLL) ? bitrev(operand_q) : operand_q;

  shift_rshift_core u_core (
    .i_data  (core_in),
    .i_shamt (shamt_q[4:0]),
    .o_data  (core_out)
  );

  // Inverting the shifted all-ones word yields the mask of vacated high bits for sign fill.
  shift_rshift_core u_fill (
    .i_data  (32'hFFFF_FFFF),
    .i_shamt (shamt_q[4:0]),
    .o_data  (fill_out)
  );

`ifdef SHIFT_ROTATE_EN
  assign ror_res = 32'({operand_q, operand_q} >> shamt_q[4:0]);
  assign ror_ill = 1'b0;
`else
  assign ror_res = 32'b0;
  assign ror_ill = 1'b1;
`endif

  always_comb begin
    srl_res   = sat ? 32'b0 : core_out;
    sra_res   = sat ? {32{sign}} : (core_out | (sign ? ~fill_out : 32'b0));
    sll_res   = sat ? 32'b0 : bitrev(core_out);
    result_d  = (op_q == OP_SRL) ? srl_res :
                (op_q == OP_SRA) ? sra_res :
                (op_q == OP_SLL) ? sll_res : ror_res;
    illegal_d = (op_q == 2'd3) & ror_ill;
  end

  // CALC spans CALC_CYCLES+1 cycles: the first one settles the latched operands through the core.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      op_q        <= 2'b0;
      operand_q   <= 32'b0;
      shamt_q     <= 32'b0;
      cnt_q       <= 3'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= 32'b0;
    end else begin
      case (state_q)
        IDLE: if (i_req_valid && req_ready_q) begin
          op_q        <= i_op;
          operand_q   <= i_operand;
          shamt_q     <= shamt_d;
          cnt_q       <= 3'b0;
          req_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          state_q     <= CALC;
        end
        CALC: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == LAST) begin
            result_q    <= result_d;
            illegal_q   <= illegal_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: if (i_rsp_ready) begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_result    = result_q;
  assign o_illegal   = illegal_q;
  assign o_busy      = busy_q;
endmodule

// File: tb/tb_shift_op_sequencer.sv
// tb_shift_op_sequencer: table-driven scoreboard bench; u_a uses defaults, u_b uses MASK_SHAMT=0, CALC_CYCLES=3.
module tb_shift_op_sequencer;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] opnd;
    logic [31:0] sh;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        ia;
    logic        ib;
  } vec_t;

  logic clk = 0, rst_n = 0, a_req_valid = 0, b_req_valid = 0, rsp_ready = 0;
  logic [1:0] op = 0;
  logic [31:0] operand = 0, shamt = 0;
  logic a_ready, a_valid, a_illegal, a_busy, b_ready, b_valid, b_illegal, b_busy;
  logic [31:0] a_result, b_result;
  int n_vec = 0, n_fail = 0, cyc = 0;
  int acc_a = 0, acc_b = 0, hs_a = 0, nacc_a = 0;
  logic pa_valid = 0, pa_rdy = 0, pb_valid = 0, pb_rdy = 0;
  logic [32:0] pa_out = 0, pb_out = 0;
  logic [32:0] qa[$], qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  shift_op_sequencer u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(a_req_valid), .o_req_ready(a_ready),
    .i_op(op), .i_operand(operand), .i_shamt(shamt), .o_rsp_valid(a_valid),
    .i_rsp_ready(rsp_ready), .o_result(a_result), .o_illegal(a_illegal), .o_busy(a_busy)
  );

  shift_op_sequencer #(.MASK_SHAMT(0), .CALC_CYCLES(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(b_req_valid), .o_req_ready(b_ready),
    .i_op(op), .i_operand(operand), .i_shamt(shamt), .o_rsp_valid(b_valid),
    .i_rsp_ready(rsp_ready), .o_result(b_result), .o_illegal(b_illegal), .o_busy(b_busy)
  );

  function automatic void chk(string name, logic [32:0] act, logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will do.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_req_valid && a_ready) begin acc_a = cyc + 1; nacc_a++; end
      if (b_req_valid && b_ready) acc_b = cyc + 1;
      if (a_valid && !pa_valid) chk("lat_a", 33'(cyc), 33'(acc_a + 2));
      if (b_valid && !pb_valid) chk("lat_b", 33'(cyc), 33'(acc_b + 4));
      if (a_valid && pa_valid && !pa_rdy) chk("hold_a", {a_illegal, a_result}, pa_out);
      if (b_valid && pb_valid && !pb_rdy) chk("hold_b", {b_illegal, b_result}, pb_out);
      chk("busy_a", {32'b0, a_busy}, {32'b0, !a_ready});
      chk("busy_b", {32'b0, b_busy}, {32'b0, !b_ready});
      if (a_valid && rsp_ready) begin
        hs_a = cyc + 1;
        if (qa.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL rsp_a: unexpected response %h, expected none", {a_illegal, a_result});
        end else chk("rsp_a", {a_illegal, a_result}, qa.pop_front());
      end
      if (b_valid && rsp_ready) begin
        if (qb.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL rsp_b: unexpected response %h, expected none", {b_illegal, b_result});
        end else chk("rsp_b", {b_illegal, b_result}, qb.pop_front());
      end
    end
    pa_valid = a_valid; pa_rdy = rsp_ready; pa_out = {a_illegal, a_result};
    pb_valid = b_valid; pb_rdy = rsp_ready; pb_out = {b_illegal, b_result};
  end

  task automatic issue(input vec_t v, input bit use_b);
    op = v.op; operand = v.opnd; shamt = v.sh;
    a_req_valid = 1'b1; b_req_valid = use_b;
    qa.push_back({v.ia, v.ra});
    if (use_b) qb.push_back({v.ib, v.rb});
    @(posedge clk); #1;
    a_req_valid = 1'b0; b_req_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || !a_ready || !b_ready) && n < bound) begin
      @(posedge clk); #1; n++;
    end
    if (qa.size() != 0 || qb.size() != 0 || !a_ready || !b_ready) begin
      n_vec++; n_fail++;
      $display("FAIL drain: outstanding a=%0d b=%0d after %0d cycles, expected 0", qa.size(), qb.size(), bound);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[14];
    vec_t v;
    int n, base;
    tbl[0]  = '{2'd0, 32'h8000_00F0, 32'd4,          32'h0800_000F, 32'h0800_000F, 1'b0, 1'b0};
    tbl[1]  = '{2'd1, 32'hF000_0000, 32'h24,         32'hFF00_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[2]  = '{2'd2, 32'h0000_0001, 32'd40,         32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0};
    tbl[3]  = '{2'd2, 32'h0000_0001, 32'd31,         32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
    tbl[4]  = '{2'd3, 32'h1234_5678, 32'd8,          32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    tbl[5]  = '{2'd1, 32'h8000_0000, 32'd0,          32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
    tbl[6]  = '{2'd0, 32'hFFFF_FFFF, 32'd16,         32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0};
    tbl[7]  = '{2'd1, 32'h7FFF_FFFF, 32'd31,         32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    tbl[8]  = '{2'd0, 32'h1234_5678, 32'd32,         32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0};
    tbl[9]  = '{2'd1, 32'h8000_0001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[10] = '{2'd2, 32'hDEAD_BEEF, 32'd4,          32'hEADB_EEF0, 32'hEADB_EEF0, 1'b0, 1'b0};
    tbl[11] = '{2'd1, 32'h8000_000F, 32'd1,          32'hC000_0007, 32'hC000_0007, 1'b0, 1'b0};
    tbl[12] = '{2'd0, 32'h8000_0000, 32'd31,         32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    tbl[13] = '{2'd2, 32'h1234_5678, 32'd33,         32'h2468_ACF0, 32'h0000_0000, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_flags", {29'b0, a_ready, a_valid, a_illegal, a_busy}, 33'b1000);
    chk("rst_b_flags", {29'b0, b_ready, b_valid, b_illegal, b_busy}, 33'b1000);
    chk("rst_a_result", {1'b0, a_result}, 33'b0);
    chk("rst_b_result", {1'b0, b_result}, 33'b0);
    rst_n = 1;
    @(posedge clk); #1;

    rsp_ready = 1;
    for (int i = 0; i < 14; i++) begin
      issue(tbl[i], 1'b1);
      drain(40);
    end

    // Stalled response: outputs must hold while downstream is not ready.
    rsp_ready = 0;
    v = '{2'd2, 32'h0000_0001, 32'd31, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
    issue(v, 1'b1);
    n = 0;
    while (!(a_valid && b_valid) && n < 20) begin @(posedge clk); #1; n++; end
    chk("stall_wait", {31'b0, a_valid, b_valid}, 33'b11);
    for (int i = 0; i < 5; i++) begin
      chk("stall_a", {a_valid, a_ready, a_result[30:0]}, {1'b1, 1'b0, 31'h0});
      chk("stall_a_msb", {32'b0, a_result[31]}, 33'b1);
      chk("stall_b", {b_valid, b_ready, b_result[30:0]}, {1'b1, 1'b0, 31'h0});
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("ready_back_a", {31'b0, a_ready, a_valid}, 33'b10);
    chk("ready_back_b", {31'b0, b_ready, b_valid}, 33'b10);
    drain(40);

    // Reset while both units are mid-CALC drops the request.
    v = '{2'd0, 32'hFFFF_FFFF, 32'd16, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0};
    issue(v, 1'b1);
    @(posedge clk); #1;
    chk("mid_calc_b_busy", {32'b0, b_busy}, 33'b1);
    rst_n = 0;
    #1;
    chk("midrst_a_flags", {29'b0, a_ready, a_valid, a_illegal, a_busy}, 33'b1000);
    chk("midrst_b_flags", {29'b0, b_ready, b_valid, b_illegal, b_busy}, 33'b1000);
    chk("midrst_a_result", {1'b0, a_result}, 33'b0);
    chk("midrst_b_result", {1'b0, b_result}, 33'b0);
    qa.delete(); qb.delete();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    issue(v, 1'b1);
    drain(40);

    // Back-to-back on u_a: second request held valid while busy.
    base = nacc_a;
    op = 2'd0; operand = 32'h8000_00F0; shamt = 32'd4;
    qa.push_back({1'b0, 32'h0800_000F});
    qa.push_back({1'b0, 32'hEADB_EEF0});
    a_req_valid = 1;
    @(posedge clk); #1;
    op = 2'd2; operand = 32'hDEAD_BEEF; shamt = 32'd4;
    n = 0;
    while (nacc_a < base + 2 && n < 20) begin @(posedge clk); #1; n++; end
    a_req_valid = 0;
    chk("b2b_accepts", 33'(nacc_a - base), 33'd2);
    chk("b2b_gap", 33'(acc_a), 33'(hs_a + 1));
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
